// File: rtl/trap_pkg.sv
// Shared types and constants for the I/O trap queue.
// Build option: TRAP_PC_CAPTURE_EN adds the captured opcode address to every record.
package trap_pkg;

    // Readback register selects
    localparam logic [2:0] SEL_STATUS  = 3'd0;
    localparam logic [2:0] SEL_PORT_LO = 3'd1;
    localparam logic [2:0] SEL_PORT_HI = 3'd2;
    localparam logic [2:0] SEL_DATA    = 3'd3;
    localparam logic [2:0] SEL_PC_LO   = 3'd4;
    localparam logic [2:0] SEL_PC_HI   = 3'd5;

    // Status byte layout: {ovf, pc_valid, dir, 0, count[3:0]}
    localparam int ST_OVF = 7;
    localparam int ST_PCV = 6;
    localparam int ST_DIR = 5;

`ifdef TRAP_PC_CAPTURE_EN
    localparam bit PC_CAP_EN = 1'b1;
`else
    localparam bit PC_CAP_EN = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } trap_state_t;

    typedef struct packed {
        logic        pc_valid;
        logic        dir;
        logic [15:0] port;
        logic [7:0]  data;
`ifdef TRAP_PC_CAPTURE_EN
        logic [15:0] pc;
`endif
    } trap_rec_t;

    localparam int REC_W = $bits(trap_rec_t);

endpackage

// File: rtl/trap_fifo.sv
// Generic register FIFO. A push into a full FIFO is accepted only when a pop
// frees the head slot in the same cycle; otherwise it is dropped and flagged.
module trap_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             dropped
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dropped = push & full & ~do_pop;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Record storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/trap_queue.sv
// Queues trapped I/O accesses from the mapper glue for hypervisor readback.
// Build option: TRAP_PC_CAPTURE_EN stores the opcode address with each record
// and exposes it on rd_sel 4/5.
module trap_queue
    import trap_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr_bus,
    input  logic [7:0]  data_in,
    input  logic        capture_addr,
    input  logic        io_violation_cond,
    input  logic        io_direction,
    input  logic [2:0]  rd_sel,
    input  logic        rd_en,
    input  logic        pop,
    input  logic        clr_ovf,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        not_empty,
    output logic        overflow
);
    logic             viol_q, cap_q;
    logic             viol_rise, cap_rise;
    trap_state_t      state, state_n;
    trap_rec_t        rec, head_rec;
    logic [REC_W-1:0] fifo_head;
    logic             fifo_full, fifo_empty, fifo_drop;
    logic [CNT_W-1:0] count;
    logic [7:0]       rd_byte;
`ifdef TRAP_PC_CAPTURE_EN
    logic [15:0]      pc_hold;
`endif

    assign viol_rise = io_violation_cond & ~viol_q;
    assign cap_rise  = capture_addr & ~cap_q;

    // Edge-detect history. Under reset it loads the live level rather than 0,
    // which leaves no pending edge: a violation held across reset was already
    // reported (or discarded with the queue) and must not be pushed again.
    always_ff @(posedge clk) begin
        viol_q <= io_violation_cond;
        cap_q  <= capture_addr;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_n;
    end

    // ARMED means an opcode address is waiting to be attached to the next trap
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (cap_rise) state_n = ST_ARMED;
            ST_ARMED: begin
                if (cap_rise)       state_n = ST_ARMED;
                else if (viol_rise) state_n = ST_IDLE;
            end
            default:  state_n = ST_IDLE;
        endcase
    end

`ifdef TRAP_PC_CAPTURE_EN
    // Latest opcode address; the push in the same cycle still sees the old value
    always_ff @(posedge clk) begin
        if (!reset_n)      pc_hold <= '0;
        else if (cap_rise) pc_hold <= addr_bus;
    end
`endif

    // Record assembled from the violation cycle's buses
    always_comb begin
        rec          = '0;
        rec.pc_valid = (state == ST_ARMED);
        rec.dir      = io_direction;
        rec.port     = addr_bus;
        rec.data     = io_direction ? data_in : 8'h00;
`ifdef TRAP_PC_CAPTURE_EN
        rec.pc       = pc_hold;
`endif
    end

    trap_fifo #(.DEPTH(DEPTH), .W(REC_W), .CNT_W(CNT_W)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (viol_rise),
        .pop     (pop),
        .din     (rec),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count),
        .dropped (fifo_drop)
    );

    // Stale storage must never leak out when the queue is empty
    assign head_rec  = fifo_empty ? '0 : trap_rec_t'(fifo_head);
    assign not_empty = ~fifo_empty;

    // Sticky overflow; a drop in the same cycle beats the clear
    always_ff @(posedge clk) begin
        if (!reset_n)       overflow <= 1'b0;
        else if (fifo_drop) overflow <= 1'b1;
        else if (clr_ovf)   overflow <= 1'b0;
    end

    // Readback mux over pre-edge state, so a coincident pop still shows the old head
    always_comb begin
        rd_byte = 8'h00;
        case (rd_sel)
            SEL_STATUS: begin
                rd_byte[ST_OVF] = overflow;
                rd_byte[ST_PCV] = PC_CAP_EN & head_rec.pc_valid;
                rd_byte[ST_DIR] = head_rec.dir;
                rd_byte[3:0]    = 4'(count);
            end
            SEL_PORT_LO: rd_byte = head_rec.port[7:0];
            SEL_PORT_HI: rd_byte = head_rec.port[15:8];
            SEL_DATA:    rd_byte = head_rec.data;
`ifdef TRAP_PC_CAPTURE_EN
            SEL_PC_LO:   rd_byte = head_rec.pc[7:0];
            SEL_PC_HI:   rd_byte = head_rec.pc[15:8];
`endif
            default:     rd_byte = 8'h00;
        endcase
    end

    // One-cycle registered readback with a single-cycle drive enable
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out <= 8'h00;
            data_oe  <= 1'b0;
        end else begin
            data_out <= rd_en ? rd_byte : 8'h00;
            data_oe  <= rd_en;
        end
    end

endmodule
